// File: rtl/solver_sequencer_if.sv
// Bus bundle between the solver sequencer, its measurement source, the linear
// solver and the result consumer.
interface solver_sequencer_if #(
    parameter int W = 32
);
    logic                  meas_valid;
    logic                  meas_ready;
    logic signed [W-1:0]   meas_x;
    logic signed [W-1:0]   meas_y;
    logic signed [W-1:0]   meas_z;
    logic signed [W-1:0]   meas_r;

    logic [4*W-1:0]        sol_x;
    logic [4*W-1:0]        sol_y;
    logic [4*W-1:0]        sol_z;
    logic [4*W-1:0]        sol_r;
    logic                  sol_en;
    logic                  sol_done;
    logic signed [W-1:0]   sol_c1;
    logic signed [W-1:0]   sol_c2;
    logic signed [W-1:0]   sol_c3;

    logic                  res_valid;
    logic                  res_ready;
    logic signed [W-1:0]   res_c1;
    logic signed [W-1:0]   res_c2;
    logic signed [W-1:0]   res_c3;
    logic                  res_timeout;

    // The sequencer itself is the master side.
    modport master (
        input  meas_valid, meas_x, meas_y, meas_z, meas_r,
        output meas_ready,
        output sol_x, sol_y, sol_z, sol_r, sol_en,
        input  sol_done, sol_c1, sol_c2, sol_c3,
        output res_valid, res_c1, res_c2, res_c3, res_timeout,
        input  res_ready
    );

    modport slave (
        output meas_valid, meas_x, meas_y, meas_z, meas_r,
        input  meas_ready,
        input  sol_x, sol_y, sol_z, sol_r, sol_en,
        output sol_done, sol_c1, sol_c2, sol_c3,
        input  res_valid, res_c1, res_c2, res_c3, res_timeout,
        output res_ready
    );
endinterface

// File: rtl/solver_sequencer.sv
// Collects four satellite measurements, runs the external linear solver with a
// bounded timeout, and holds the result (or a timeout marker) until consumed.
module solver_sequencer #(
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                abort,
    solver_sequencer_if.master  bus,
    output logic [1:0]          state,
    output logic [7:0]          solve_cnt
);
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RUN     = 2'd1,
        OUT     = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [7:0]            timer_q, timer_d;
    logic [4*W-1:0]        sol_x_q, sol_x_d;
    logic [4*W-1:0]        sol_y_q, sol_y_d;
    logic [4*W-1:0]        sol_z_q, sol_z_d;
    logic [4*W-1:0]        sol_r_q, sol_r_d;
    logic signed [W-1:0]   res_c1_q, res_c1_d;
    logic signed [W-1:0]   res_c2_q, res_c2_d;
    logic signed [W-1:0]   res_c3_q, res_c3_d;
    logic                  res_timeout_q, res_timeout_d;
    logic                  res_valid_q, res_valid_d;
    logic [7:0]            solve_cnt_q, solve_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= COLLECT;
            idx_q         <= '0;
            timer_q       <= '0;
            sol_x_q       <= '0;
            sol_y_q       <= '0;
            sol_z_q       <= '0;
            sol_r_q       <= '0;
            res_c1_q      <= '0;
            res_c2_q      <= '0;
            res_c3_q      <= '0;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b0;
            solve_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            sol_x_q       <= sol_x_d;
            sol_y_q       <= sol_y_d;
            sol_z_q       <= sol_z_d;
            sol_r_q       <= sol_r_d;
            res_c1_q      <= res_c1_d;
            res_c2_q      <= res_c2_d;
            res_c3_q      <= res_c3_d;
            res_timeout_q <= res_timeout_d;
            res_valid_q   <= res_valid_d;
            solve_cnt_q   <= solve_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        sol_x_d       = sol_x_q;
        sol_y_d       = sol_y_q;
        sol_z_d       = sol_z_q;
        sol_r_d       = sol_r_q;
        res_c1_d      = res_c1_q;
        res_c2_d      = res_c2_q;
        res_c3_d      = res_c3_q;
        res_timeout_d = res_timeout_q;
        res_valid_d   = res_valid_q;
        solve_cnt_d   = solve_cnt_q;

        // Abort beats every handshake and solver completion in the same cycle.
        if (abort) begin
            state_d     = COLLECT;
            idx_d       = '0;
            timer_d     = '0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (bus.meas_valid) begin
                        sol_x_d[int'(idx_q)*W +: W] = bus.meas_x;
                        sol_y_d[int'(idx_q)*W +: W] = bus.meas_y;
                        sol_z_d[int'(idx_q)*W +: W] = bus.meas_z;
                        sol_r_d[int'(idx_q)*W +: W] = bus.meas_r;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = RUN;
                            timer_d = '0;
                        end
                    end
                end
                RUN: begin
                    timer_d = timer_q + 8'd1;
                    if (bus.sol_done) begin
                        res_c1_d      = bus.sol_c1;
                        res_c2_d      = bus.sol_c2;
                        res_c3_d      = bus.sol_c3;
                        res_timeout_d = 1'b0;
                        solve_cnt_d   = solve_cnt_q + 8'd1;
                        res_valid_d   = 1'b1;
                        state_d       = OUT;
                    end else if (timer_q == TIMER_LAST) begin
                        res_c1_d      = '0;
                        res_c2_d      = '0;
                        res_c3_d      = '0;
                        res_timeout_d = 1'b1;
                        res_valid_d   = 1'b1;
                        state_d       = OUT;
                    end
                end
                OUT: begin
                    if (res_valid_q && bus.res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = COLLECT;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign bus.meas_ready  = (state_q == COLLECT);
    assign bus.sol_en      = (state_q == RUN);
    assign bus.sol_x       = sol_x_q;
    assign bus.sol_y       = sol_y_q;
    assign bus.sol_z       = sol_z_q;
    assign bus.sol_r       = sol_r_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_c1      = res_c1_q;
    assign bus.res_c2      = res_c2_q;
    assign bus.res_c3      = res_c3_q;
    assign bus.res_timeout = res_timeout_q;
    assign state           = state_q;
    assign solve_cnt       = solve_cnt_q;
endmodule

// File: tb/tb_solver_sequencer.sv
// Self-checking bench for solver_sequencer: randomized measurements and solver
// latencies checked against a lane/count model kept in the bench.
`timescale 1ns/1ps
module tb_solver_sequencer;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] state;
    logic [7:0] solve_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: what each lane should hold, next lane to load, solve count.
    logic [W-1:0] lane_x [4];
    logic [W-1:0] lane_y [4];
    logic [W-1:0] lane_z [4];
    logic [W-1:0] lane_r [4];
    int           model_idx = 0;
    int           exp_cnt   = 0;

    solver_sequencer_if #(.W(W)) bus();

    solver_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .bus       (bus),
        .state     (state),
        .solve_cnt (solve_cnt)
    );

    always #5 clk = ~clk;

    // Drive one measurement for one cycle (valid left high for back-to-back use).
    task automatic load_meas(input logic [W-1:0] x, y, z, r);
        bus.meas_valid = 1'b1;
        bus.meas_x = x;
        bus.meas_y = y;
        bus.meas_z = z;
        bus.meas_r = r;
        lane_x[model_idx] = x;
        lane_y[model_idx] = y;
        lane_z[model_idx] = z;
        lane_r[model_idx] = r;
        model_idx = (model_idx + 1) % 4;
        @(negedge clk);
    endtask

    task automatic load_random_four();
        for (int i = 0; i < 4; i++)
            load_meas($urandom, $urandom, $urandom, $urandom);
        bus.meas_valid = 1'b0;
    endtask

    // Act as the solver: raise done after 'delay' RUN cycles, report enable length.
    task automatic drive_run(input int delay, input logic [W-1:0] c1, c2, c3,
                             output int en_cycles);
        en_cycles = 0;
        for (int k = 0; k < TIMEOUT + 4; k++) begin
            if (bus.sol_en !== 1'b1) break;
            en_cycles++;
            bus.sol_done = (k == delay);
            bus.sol_c1 = (k == delay) ? c1 : $urandom;
            bus.sol_c2 = (k == delay) ? c2 : $urandom;
            bus.sol_c3 = (k == delay) ? c3 : $urandom;
            @(negedge clk);
        end
        bus.sol_done = 1'b0;
    endtask

    task automatic consume(input int hold);
        bus.res_ready = 1'b0;
        repeat (hold) @(negedge clk);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (state !== 2'd0 || bus.meas_ready !== 1'b1 || bus.sol_en !== 1'b0 ||
            bus.res_valid !== 1'b0 || bus.res_timeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl state=%0d ready=%b en=%b valid=%b to=%b, want 0/1/0/0/0",
                     state, bus.meas_ready, bus.sol_en, bus.res_valid, bus.res_timeout);
        end
        checks++;
        if (bus.sol_x !== '0 || bus.sol_y !== '0 || bus.sol_z !== '0 || bus.sol_r !== '0 ||
            bus.res_c1 !== '0 || bus.res_c2 !== '0 || bus.res_c3 !== '0 || solve_cnt !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_data sol_x=%0h res_c1=%0h cnt=%0d, want all zero",
                     bus.sol_x, bus.res_c1, solve_cnt);
        end
    endtask

    task automatic test_basic_solve();
        logic [W-1:0] xs [4];
        int en;
        xs[0] = 32'd2088202;  xs[1] = 32'd11092568;
        xs[2] = 32'd35606984; xs[3] = 32'd3966929;
        for (int i = 0; i < 4; i++)
            load_meas(xs[i], $urandom, $urandom, $urandom);
        bus.meas_valid = 1'b0;
        checks++;
        if (state !== 2'd1 || bus.sol_en !== 1'b1 || bus.meas_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_run_entry state=%0d en=%b ready=%b, want 1/1/0",
                     state, bus.sol_en, bus.meas_ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.sol_x[i*W +: W] !== xs[i] || bus.sol_y[i*W +: W] !== lane_y[i] ||
                bus.sol_z[i*W +: W] !== lane_z[i] || bus.sol_r[i*W +: W] !== lane_r[i]) begin
                failures++;
                $display("[TB] FAIL basic_lane%0d x=%0d want %0d", i, bus.sol_x[i*W +: W], xs[i]);
            end
        end
        drive_run(5, 32'd10, 32'd20, 32'd30, en);
        exp_cnt = (exp_cnt + 1) % 256;
        checks++;
        if (en != 6) begin
            failures++;
            $display("[TB] FAIL basic_en_cycles got=%0d want=6", en);
        end
        checks++;
        if (state !== 2'd2 || bus.res_valid !== 1'b1 || bus.res_timeout !== 1'b0 ||
            bus.res_c1 !== 32'sd10 || bus.res_c2 !== 32'sd20 || bus.res_c3 !== 32'sd30 ||
            solve_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("[TB] FAIL basic_result valid=%b to=%b c=(%0d,%0d,%0d) cnt=%0d, want 1/0/(10,20,30)/%0d",
                     bus.res_valid, bus.res_timeout, bus.res_c1, bus.res_c2, bus.res_c3,
                     solve_cnt, exp_cnt);
        end
        consume(0);
        checks++;
        if (state !== 2'd0 || bus.res_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_consume state=%0d valid=%b, want 0/0", state, bus.res_valid);
        end
    endtask

    task automatic test_timeout();
        int en;
        load_random_four();
        drive_run(1000, '0, '0, '0, en);
        checks++;
        if (en != TIMEOUT) begin
            failures++;
            $display("[TB] FAIL timeout_en_cycles got=%0d want=%0d", en, TIMEOUT);
        end
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_timeout !== 1'b1 || bus.res_c1 !== '0 ||
            bus.res_c2 !== '0 || bus.res_c3 !== '0 || solve_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("[TB] FAIL timeout_result valid=%b to=%b c1=%0d cnt=%0d, want 1/1/0/%0d",
                     bus.res_valid, bus.res_timeout, bus.res_c1, solve_cnt, exp_cnt);
        end
        consume(1);
    endtask

    task automatic test_out_hold();
        int en;
        logic [W-1:0] c1, c2, c3;
        c1 = $urandom; c2 = $urandom; c3 = $urandom;
        load_random_four();
        drive_run(2, c1, c2, c3, en);
        exp_cnt = (exp_cnt + 1) % 256;
        bus.res_ready = 1'b0;
        // Offer a measurement while busy: it must not land in any lane.
        bus.meas_valid = 1'b1;
        bus.meas_x = $urandom;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_c1 !== c1 || bus.res_c2 !== c2 ||
                bus.res_c3 !== c3 || bus.meas_ready !== 1'b0 || bus.sol_en !== 1'b0 ||
                bus.sol_x[0 +: W] !== lane_x[0] || bus.sol_x[3*W +: W] !== lane_x[3]) begin
                failures++;
                $display("[TB] FAIL out_hold cyc=%0d valid=%b c1=%0h want %0h ready=%b en=%b",
                         k, bus.res_valid, bus.res_c1, c1, bus.meas_ready, bus.sol_en);
            end
            @(negedge clk);
        end
        bus.meas_valid = 1'b0;
        consume(0);
        checks++;
        if (state !== 2'd0 || bus.res_valid !== 1'b0 || solve_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("[TB] FAIL out_release state=%0d valid=%b cnt=%0d, want 0/0/%0d",
                     state, bus.res_valid, solve_cnt, exp_cnt);
        end
    endtask

    task automatic test_abort();
        load_meas($urandom, $urandom, $urandom, $urandom);
        load_meas($urandom, $urandom, $urandom, $urandom);
        bus.meas_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.meas_valid = 1'b0;
        model_idx = 0;
        load_random_four();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.sol_x[i*W +: W] !== lane_x[i] || bus.sol_r[i*W +: W] !== lane_r[i]) begin
                failures++;
                $display("[TB] FAIL abort_lane%0d x=%0h want %0h", i, bus.sol_x[i*W +: W], lane_x[i]);
            end
        end
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("[TB] FAIL abort_reload_state got=%0d want=1", state);
        end
        abort = 1'b1;
        bus.sol_done = 1'b1;
        bus.sol_c1 = $urandom;
        @(negedge clk);
        abort = 1'b0;
        bus.sol_done = 1'b0;
        checks++;
        if (state !== 2'd0 || bus.res_valid !== 1'b0 || bus.sol_en !== 1'b0 ||
            solve_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("[TB] FAIL abort_run_done state=%0d valid=%b en=%b cnt=%0d, want 0/0/0/%0d",
                     state, bus.res_valid, bus.sol_en, solve_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        int delay, en, exp_en, gap;
        bit exp_to;
        logic [W-1:0] c1, c2, c3;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                gap = $urandom_range(0, 2);
                bus.meas_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    bus.sol_done = $urandom_range(0, 1);
                    @(negedge clk);
                end
                bus.sol_done = 1'b0;
                load_meas($urandom, $urandom, $urandom, $urandom);
            end
            bus.meas_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (bus.sol_x[i*W +: W] !== lane_x[i] || bus.sol_y[i*W +: W] !== lane_y[i] ||
                    bus.sol_z[i*W +: W] !== lane_z[i] || bus.sol_r[i*W +: W] !== lane_r[i]) begin
                    failures++;
                    $display("[TB] FAIL rand_lane n=%0d i=%0d x=%0h want %0h",
                             n, i, bus.sol_x[i*W +: W], lane_x[i]);
                end
            end
            case (n % 5)
                0: delay = TIMEOUT - 1;
                1: delay = TIMEOUT + 10;
                default: delay = $urandom_range(0, TIMEOUT + 5);
            endcase
            c1 = $urandom; c2 = $urandom; c3 = $urandom;
            drive_run(delay, c1, c2, c3, en);
            exp_to = (delay >= TIMEOUT);
            exp_en = exp_to ? TIMEOUT : delay + 1;
            if (!exp_to) exp_cnt = (exp_cnt + 1) % 256;
            checks++;
            if (en != exp_en || bus.res_valid !== 1'b1 || bus.res_timeout !== exp_to ||
                bus.res_c1 !== (exp_to ? '0 : c1) || bus.res_c2 !== (exp_to ? '0 : c2) ||
                bus.res_c3 !== (exp_to ? '0 : c3) || solve_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("[TB] FAIL rand_solve n=%0d delay=%0d en=%0d want %0d to=%b want %b c1=%0h cnt=%0d want %0d",
                         n, delay, en, exp_en, bus.res_timeout, exp_to, bus.res_c1, solve_cnt, exp_cnt);
            end
            consume($urandom_range(0, 3));
        end
    endtask

    task automatic test_async_reset();
        load_random_four();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || bus.sol_en !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.meas_ready !== 1'b1 || bus.res_timeout !== 1'b0 || bus.sol_x !== '0 ||
            bus.sol_r !== '0 || bus.res_c1 !== '0 || solve_cnt !== 8'd0) begin
            failures++;
            $display("[TB] FAIL async_reset state=%0d en=%b valid=%b ready=%b cnt=%0d sol_x=%0h",
                     state, bus.sol_en, bus.res_valid, bus.meas_ready, solve_cnt, bus.sol_x);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        model_idx = 0;
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b0 || state !== 2'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_release valid=%b state=%0d, want 0/0",
                     bus.res_valid, state);
        end
    endtask

    task automatic test_wrap();
        int en;
        for (int n = 0; n < 256; n++) begin
            load_random_four();
            drive_run(0, $urandom, $urandom, $urandom, en);
            exp_cnt = (exp_cnt + 1) % 256;
            checks++;
            if (solve_cnt !== 8'(exp_cnt) || bus.res_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL wrap_count n=%0d cnt=%0d want %0d valid=%b",
                         n, solve_cnt, exp_cnt, bus.res_valid);
            end
            consume(0);
        end
        checks++;
        if (solve_cnt !== 8'd0) begin
            failures++;
            $display("[TB] FAIL wrap_final cnt=%0d want 0", solve_cnt);
        end
    endtask

    initial begin
        bus.meas_valid = 1'b0;
        bus.meas_x = '0; bus.meas_y = '0; bus.meas_z = '0; bus.meas_r = '0;
        bus.sol_done = 1'b0;
        bus.sol_c1 = '0; bus.sol_c2 = '0; bus.sol_c3 = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lane_x[i] = '0; lane_y[i] = '0; lane_z[i] = '0; lane_r[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_solve();
        test_timeout();
        test_out_hold();
        test_abort();
        test_random();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/solver_sequencer.md
SOLVER_SEQUENCER -- requirements
Module: solver_sequencer

Interface
REQ-001 SHALL have parameter W, default 32, meaning signed fixed-point width of every coordinate, range and result word.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of RUN cycles allowed per solve (legal range 2..255).
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 abort  in  1  synchronous abort of the current operation.
REQ-006 meas_valid  in  1  measurement offered.
REQ-007 meas_ready  out  1  measurement can be accepted.
REQ-008 meas_x, meas_y, meas_z, meas_r  in  W each  satellite position and pseudorange.
REQ-009 sol_x, sol_y, sol_z, sol_r  out  4*W each  packed operand banks to the linear solver; lane i is bits [i*W +: W] and holds measurement i.
REQ-010 sol_en  out  1  solver enable.
REQ-011 sol_done  in  1  solver result valid.
REQ-012 sol_c1, sol_c2, sol_c3  in  W each  solver result.
REQ-013 res_valid  out  1  result available.
REQ-014 res_ready  in  1  result consumed.
REQ-015 res_c1, res_c2, res_c3  out  W each  captured result.
REQ-016 res_timeout  out  1  result is a timeout, not a solution.
REQ-017 state  out  2  current state: COLLECT=0, RUN=1, OUT=2.
REQ-018 solve_cnt  out  8  count of successful solves.

Function
REQ-019 SHALL implement three states: COLLECT, RUN, OUT.
REQ-020 COLLECT: meas_ready=1; a handshake (meas_valid&meas_ready) writes the inputs into lane idx and increments the 2-bit idx.
REQ-021 A handshake with idx=3 SHALL clear idx to 0 and enter RUN on the next edge; sol_en SHALL be 1 in the first RUN cycle.
REQ-022 meas_ready SHALL be 0 in RUN and OUT; sol_x/y/z/r SHALL remain stable outside COLLECT handshakes.
REQ-023 RUN: sol_en=1; an 8-bit timer cleared on RUN entry increments each RUN cycle.
REQ-024 In RUN, sol_done=1 SHALL capture sol_c1..c3 into res_c1..c3, clear res_timeout, increment solve_cnt (wraps 255->0) and enter OUT.
REQ-025 In RUN, sol_done=0 with timer=TIMEOUT-1 SHALL zero res_c1..c3, set res_timeout, leave solve_cnt unchanged and enter OUT; RUN therefore lasts at most TIMEOUT cycles.
REQ-026 If sol_done and the timeout condition coincide, done SHALL win.
REQ-027 OUT: res_valid=1 and sol_en=0; res_valid&res_ready SHALL return the block to COLLECT with res_valid=0 on the next edge.
REQ-028 res_c*/res_timeout SHALL hold while res_valid=1; res_valid is registered, so the earliest consume is the cycle after OUT entry.
REQ-029 sol_done outside RUN SHALL be ignored.
REQ-030 abort=1 SHALL, on the next edge and from any state, enter COLLECT, clear idx, timer, res_valid and sol_en, and discard partially loaded lanes; it overrides every handshake and sol_done in the same cycle; solve_cnt is kept.
REQ-031 sol_en SHALL be low for at least one cycle between consecutive solves.

Reset
REQ-032 rst_n=0 SHALL immediately force state=COLLECT, idx=0, timer=0, sol_en=0, res_valid=0, res_timeout=0, res_c*=0, sol_x/y/z/r=0 and solve_cnt=0; meas_ready=1 immediately after reset.
REQ-033 Reset asserted mid-RUN or mid-OUT SHALL abandon the solve with no result output.

Verification
REQ-034 Load 4 measurements back-to-back (x lanes 2088202, 11092568, 35606984, 3966929); solver raises done 5 cycles later with c=(10,20,30) -> sol_x lanes match, sol_en rises the cycle after the 4th handshake, res_valid=1 with res_c=(10,20,30), res_timeout=0, solve_cnt=1.
REQ-035 Solver never raises done, TIMEOUT=64 -> sol_en high exactly 64 cycles, then res_valid=1, res_timeout=1, res_c=0, solve_cnt unchanged.
REQ-036 res_ready held low for 10 cycles in OUT -> res_valid and res_c stable for all 10 cycles, meas_ready=0, sol_en=0; COLLECT is entered one cycle after res_ready=1.
REQ-037 abort after 2 handshakes, then 4 new measurements -> all four lanes hold the new values; abort in RUN coinciding with sol_done -> no result, solve_cnt unchanged.
REQ-038 rst_n pulsed low mid-RUN, asynchronously to clk -> all outputs reach their reset values before the next edge.
REQ-039 256 successful solves -> solve_cnt wraps to 0.
